// File: rtl/weight_preloader.sv
// Streams a ROWS x COLS weight tile into the mesh configuration port, then pulses start.
// Elements are accepted in row-major order; each accepted element is emitted one cycle later.
module weight_preloader #(
  parameter int unsigned DW    = 8,
  parameter int unsigned ROWS  = 16,
  parameter int unsigned COLS  = 12,
  parameter int unsigned ROW_W = 4,
  parameter int unsigned COL_W = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           load_req,
  input  logic                           abort,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic signed [DW-1:0]           in_data,
  output logic                           preload_valid,
  output logic        [ROW_W+COL_W-1:0]  preload_addr,
  output logic signed [DW-1:0]           preload_data,
  output logic                           start,
  output logic                           busy
);

  typedef enum logic [1:0] {StIdle, StLoad, StFire} state_e;

  state_e                   state_q, state_d;
  logic [ROW_W-1:0]         row_q, row_d;
  logic [COL_W-1:0]         col_q, col_d;
  logic                     pv_q, pv_d;
  logic [ROW_W+COL_W-1:0]   addr_q, addr_d;
  logic signed [DW-1:0]     data_q, data_d;
  logic                     start_q, start_d;

  logic accept;
  logic last_row;
  logic last_col;

  // abort wins over a simultaneous handshake: the element is dropped, not emitted
  assign accept   = (state_q == StLoad) && in_valid && !abort;
  assign last_row = (row_q == ROW_W'(ROWS - 1));
  assign last_col = (col_q == COL_W'(COLS - 1));

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    pv_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    start_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (load_req) begin
          state_d = StLoad;
          row_d   = '0;
          col_d   = '0;
        end
      end
      StLoad: begin
        if (abort) begin
          state_d = StIdle;
        end else if (accept) begin
          pv_d   = 1'b1;
          addr_d = {row_q, col_q};
          data_d = in_data;
          if (last_col) begin
            col_d = '0;
            if (last_row) begin
              row_d   = '0;
              state_d = StFire;
            end else begin
              row_d = row_q + 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      StFire: begin
        // the final beat is on the port this cycle; start follows it
        start_d = 1'b1;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      row_q   <= '0;
      col_q   <= '0;
      pv_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      pv_q    <= pv_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      start_q <= start_d;
    end
  end

  assign in_ready      = (state_q == StLoad);
  assign preload_valid = pv_q;
  assign preload_addr  = addr_q;
  assign preload_data  = data_q;
  assign start         = start_q;
  // start cycle is already back in StIdle but still counts as busy
  assign busy          = (state_q != StIdle) || start_q;

endmodule

// File: tb/tb_weight_preloader.sv
// Directed bench for weight_preloader: a count-based model predicts every output each cycle,
// and literal expectations pin addresses, data, beat counts and the start timing.
module tb_weight_preloader;

  localparam int DW     = 8;
  localparam int ROWS   = 16;
  localparam int COLS   = 12;
  localparam int ROW_W  = 4;
  localparam int COL_W  = 4;
  localparam int AW     = ROW_W + COL_W;
  localparam int NBEATS = ROWS * COLS;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          load_req;
  logic          abort;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          preload_valid;
  logic [AW-1:0] preload_addr;
  logic [DW-1:0] preload_data;
  logic          start;
  logic          busy;

  weight_preloader #(
    .DW   (DW),
    .ROWS (ROWS),
    .COLS (COLS),
    .ROW_W(ROW_W),
    .COL_W(COL_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_req     (load_req),
    .abort        (abort),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .preload_valid(preload_valid),
    .preload_addr (preload_addr),
    .preload_data (preload_data),
    .start        (start),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Model: m_n counts elements taken in the current load, m_active marks a load in progress,
  // m_fire marks the cycle carrying the final beat.
  int            m_n;
  logic          m_active, m_fire;
  logic          e_pv, e_start;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_data;

  always @(posedge clk or negedge rst_n) begin
    logic acc, nf;
    if (!rst_n) begin
      m_n      <= 0;
      m_active <= 1'b0;
      m_fire   <= 1'b0;
      e_pv     <= 1'b0;
      e_start  <= 1'b0;
      e_addr   <= '0;
      e_data   <= '0;
    end else begin
      acc = m_active && in_valid && !abort;
      nf  = acc && (m_n == NBEATS - 1);
      e_start <= m_fire;
      e_pv    <= acc;
      if (acc) begin
        e_addr <= {ROW_W'(m_n / COLS), COL_W'(m_n % COLS)};
        e_data <= in_data;
        m_n    <= m_n + 1;
      end
      if (m_active) begin
        if (abort || nf) m_active <= 1'b0;
      end else if (!m_fire && load_req) begin
        m_active <= 1'b1;
        m_n      <= 0;
      end
      m_fire <= nf;
    end
  end

  int            checks = 0;
  int            errors = 0;
  int            nbeats = 0;
  int            nstarts = 0;
  int            bad_col = 0;
  int            last_beat_cyc = 0;
  int            start_cyc = 0;
  logic [AW-1:0] beat_addr [0:2047];
  logic [DW-1:0] beat_data [0:2047];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_preload_valid", 32'(preload_valid), 32'd0);
        chk("rst_start", 32'(start), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_addr", 32'(preload_addr), 32'd0);
        chk("rst_data", 32'(preload_data), 32'd0);
      end else begin
        chk("in_ready", 32'(in_ready), 32'(m_active));
        chk("preload_valid", 32'(preload_valid), 32'(e_pv));
        chk("start", 32'(start), 32'(e_start));
        chk("busy", 32'(busy), 32'(m_active | m_fire | e_start));
        if (e_pv) begin
          chk("preload_addr", 32'(preload_addr), 32'(e_addr));
          chk("preload_data", 32'(preload_data), 32'(e_data));
        end
        if (preload_valid) begin
          if (nbeats < 2048) begin
            beat_addr[nbeats] = preload_addr;
            beat_data[nbeats] = preload_data;
          end
          nbeats++;
          last_beat_cyc = cyc;
          if (int'(preload_addr[COL_W-1:0]) >= COLS) bad_col++;
        end
        if (start) begin
          nstarts++;
          start_cyc = cyc;
        end
      end
    end
  endtask

  // Inputs change 2 time units after each rising edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_load();
    load_req = 1'b1;
    step();
    load_req = 1'b0;
  endtask

  task automatic send(input int n, input int base, input bit gap, input int mid);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = DW'(base + i);
      load_req = (i == mid);
      step();
      load_req = 1'b0;
      if (gap) begin
        in_valid = 1'b0;
        step();
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic run();
    int b0, s0;
    rst_n = 1'b0; load_req = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (3) step();
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    repeat (2) step();

    // back-to-back full load with values 0..191
    b0 = nbeats; s0 = nstarts;
    pulse_load();
    send(NBEATS, 0, 1'b0, -1);
    repeat (4) step();
    chk("s1_beats", 32'(nbeats - b0), 32'd192);
    chk("s1_addr0", 32'(beat_addr[b0]), 32'h00);
    chk("s1_addr11", 32'(beat_addr[b0 + 11]), 32'h0B);
    chk("s1_addr12", 32'(beat_addr[b0 + 12]), 32'h10);
    chk("s1_data100", 32'(beat_data[b0 + 100]), 32'h64);
    chk("s1_addr191", 32'(beat_addr[b0 + 191]), 32'hFB);
    chk("s1_data191", 32'(beat_data[b0 + 191]), 32'hBF);
    chk("s1_starts", 32'(nstarts - s0), 32'd1);
    chk("s1_start_after_last", 32'(start_cyc - last_beat_cyc), 32'd1);
    chk("s1_busy_low", 32'(busy), 32'd0);

    // in_valid toggling 1,0,1,0
    b0 = nbeats; s0 = nstarts;
    pulse_load();
    send(NBEATS, 8'h20, 1'b1, -1);
    repeat (4) step();
    chk("s2_beats", 32'(nbeats - b0), 32'd192);
    chk("s2_addr13", 32'(beat_addr[b0 + 13]), 32'h11);
    chk("s2_data0", 32'(beat_data[b0]), 32'h20);
    chk("s2_starts", 32'(nstarts - s0), 32'd1);
    chk("s2_start_after_last", 32'(start_cyc - last_beat_cyc), 32'd1);

    // abort after 50 acceptances, colliding with a valid element
    b0 = nbeats; s0 = nstarts;
    pulse_load();
    send(50, 0, 1'b0, -1);
    in_valid = 1'b1; in_data = 8'h77; abort = 1'b1;
    step();
    abort = 1'b0; in_data = 8'h78;
    chk("s3_ready_after_abort", 32'(in_ready), 32'd0);
    step();
    in_valid = 1'b0;
    repeat (3) step();
    chk("s3_beats", 32'(nbeats - b0), 32'd50);
    chk("s3_starts", 32'(nstarts - s0), 32'd0);
    b0 = nbeats; s0 = nstarts;
    pulse_load();
    send(NBEATS, 8'h40, 1'b0, -1);
    repeat (4) step();
    chk("s3_restart_addr", 32'(beat_addr[b0]), 32'h00);
    chk("s3_restart_data", 32'(beat_data[b0]), 32'h40);
    chk("s3_restart_beats", 32'(nbeats - b0), 32'd192);
    chk("s3_restart_starts", 32'(nstarts - s0), 32'd1);

    // load_req repeated mid-load at element 100
    b0 = nbeats; s0 = nstarts;
    pulse_load();
    send(NBEATS, 0, 1'b0, 100);
    repeat (4) step();
    chk("s4_beats", 32'(nbeats - b0), 32'd192);
    chk("s4_addr100", 32'(beat_addr[b0 + 100]), 32'h84);
    chk("s4_addr191", 32'(beat_addr[b0 + 191]), 32'hFB);
    chk("s4_starts", 32'(nstarts - s0), 32'd1);

    // reset at element 80, then a fresh load
    pulse_load();
    send(80, 8'h10, 1'b0, -1);
    in_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("s5_async_pv", 32'(preload_valid), 32'd0);
    chk("s5_async_addr", 32'(preload_addr), 32'd0);
    chk("s5_async_data", 32'(preload_data), 32'd0);
    chk("s5_async_busy", 32'(busy), 32'd0);
    repeat (3) step();
    rst_n = 1'b1;
    b0 = nbeats;
    repeat (5) step();
    chk("s5_idle_no_beats", 32'(nbeats - b0), 32'd0);
    chk("s5_idle_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    b0 = nbeats; s0 = nstarts;
    pulse_load();
    send(NBEATS, 8'hC8, 1'b0, -1);
    repeat (4) step();
    chk("s5_first_addr", 32'(beat_addr[b0]), 32'h00);
    chk("s5_first_data", 32'(beat_data[b0]), 32'hC8);
    chk("s5_beats", 32'(nbeats - b0), 32'd192);
    chk("s5_starts", 32'(nstarts - s0), 32'd1);

    chk("no_col_ge_cols", 32'(bad_col), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  initial begin
    fork
      monitor();
      run();
    join
  end

endmodule

// File: doc/weight_preloader.md
WEIGHT_PRELOADER -- requirements
Module: weight_preloader

Interface
REQ-001 Parameter DW, default 8: weight element width in bits, two's complement.
REQ-002 Parameter ROWS, default 16: mesh rows to load.
REQ-003 Parameter COLS, default 12: mesh columns to load.
REQ-004 Parameter ROW_W, default 4: row index width; ROWS <= 2**ROW_W.
REQ-005 Parameter COL_W, default 4: column index width; COLS <= 2**COL_W.
REQ-006 Port clk, input, 1: single clock; all state SHALL update on its rising edge.
REQ-007 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-008 Port load_req, input, 1: single-cycle request to begin a full weight load.
REQ-009 Port abort, input, 1: synchronous cancel of a load in progress.
REQ-010 Port in_valid, input, 1: upstream weight element valid.
REQ-011 Port in_ready, output, 1: block accepts an element this cycle.
REQ-012 Port in_data, input, DW, signed: upstream weight element, row-major order.
REQ-013 Port preload_valid, output, 1: write strobe to the mesh configuration port.
REQ-014 Port preload_addr, output, ROW_W+COL_W: {row, col}, with row in the upper ROW_W bits.
REQ-015 Port preload_data, output, DW, signed: weight value for preload_addr.
REQ-016 Port start, output, 1: single-cycle compute trigger to the array controller.
REQ-017 Port busy, output, 1: high from load acceptance until the start pulse, inclusive.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, LOAD and FIRE.
REQ-019 IDLE -> LOAD SHALL occur on load_req=1; load_req in LOAD or FIRE SHALL be ignored.
REQ-020 On entry to LOAD, the row and column counters SHALL clear to 0.
REQ-021 in_ready SHALL be 1 only in LOAD and SHALL be a registered or state-decoded signal, not a function of in_valid.
REQ-022 An element is accepted in a cycle when in_valid=1 and in_ready=1; no other cycle SHALL consume data.
REQ-023 An element accepted in cycle t SHALL appear on preload_valid=1, preload_addr and preload_data in cycle t+1 (latency 1), for exactly one cycle.
REQ-024 preload_valid SHALL be 0 in every cycle not following an acceptance, and in_valid gaps SHALL insert matching preload_valid gaps.
REQ-025 After each acceptance, col SHALL increment; at col=COLS-1 it SHALL wrap to 0 and row SHALL increment.
REQ-026 Acceptance of element (ROWS-1, COLS-1) SHALL transition LOAD -> FIRE, and in_ready SHALL drop the next cycle.
REQ-027 In FIRE, the last preload_valid beat is output; start SHALL pulse 1 in the cycle immediately after that beat, and the state SHALL return to IDLE.
REQ-028 Exactly ROWS*COLS preload beats SHALL precede each start pulse, and addresses with col >= COLS SHALL never be emitted.
REQ-029 When abort=1 in LOAD, the block SHALL return to IDLE next cycle with no start pulse; a beat already registered SHALL still be emitted.
REQ-030 abort SHALL take priority over a simultaneous acceptance; that element SHALL NOT be emitted.
REQ-031 abort in IDLE or FIRE SHALL have no effect.
REQ-032 preload_data SHALL pass in_data bit-exact, with no sign change or width change.
REQ-033 busy SHALL be 1 in LOAD and FIRE and during the start cycle, and 0 otherwise.

Reset
REQ-034 While rst_n=0, the block SHALL be in IDLE with counters at 0, and in_ready, preload_valid, start and busy at 0.
REQ-035 While rst_n=0, preload_addr and preload_data SHALL be 0.
REQ-036 Reset asserted mid-load SHALL discard all progress; after release, the block SHALL remain in IDLE until a new load_req.
REQ-037 Reset SHALL be asserted asynchronously and deasserted synchronously to clk.

Verification
REQ-038 Scenario: load_req, then 192 back-to-back elements with values 0..191 -> beat k has addr {k/12, k%12} and data k; start pulses one cycle after beat 191; busy then falls.
REQ-039 Scenario: in_valid toggling 1,0,1,0 -> preload_valid mirrors it with one cycle of delay; the same addresses occur in the same order; still exactly 192 beats.
REQ-040 Scenario: the 12th element (row 0, col 11) -> the next beat is addr 0x10 (row 1, col 0); addresses 0x0C..0x0F never appear.
REQ-041 Scenario: abort after 50 acceptances, with in_valid=1 -> 50 beats emitted, no start; in_ready is 0 the next cycle; a new load_req restarts at addr 0x00.
REQ-042 Scenario: load_req pulsed mid-load at element 100 -> no counter reset; the total is still 192 beats followed by one start.
REQ-043 Scenario: rst_n=0 at element 80, then released, then a new load -> all outputs are 0 during reset; the new load begins at addr 0x00 with data from the first new element.
